// File: rtl/rf_access_sequencer_pkg.sv
// Shared widths and FSM encodings for the register-file access sequencer.
package rf_access_sequencer_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 5;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RD_ISSUE   = 3'd1,
      ST_RD_CAPTURE = 3'd2,
      ST_RSP        = 3'd3,
      ST_WR_ISSUE   = 3'd4
   } seq_state_e;

endpackage

// File: rtl/rf_access_sequencer.sv
// Initiator for the 32x32 dual-read register file: sequences one read or write per
// request onto the RF pins and returns read data through a held valid/ready response.
module rf_access_sequencer
   import rf_access_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter bit PROTECT_R0 = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_WR,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR_A,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR_B,
   input  logic [DATA_WIDTH-1:0] REQ_WDATA,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [DATA_WIDTH-1:0] RSP_DATA_A,
   output logic [DATA_WIDTH-1:0] RSP_DATA_B,
   output logic                  WR_DONE,
   output logic                  RF_READ,
   output logic                  RF_WRITE,
   output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
   output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
   output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
   output logic [DATA_WIDTH-1:0] RF_DATA_W,
   input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
   input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
   output logic [2:0]            DBG_STATE
);

   // Handshakes: a request transfers on an edge where REQ_VALID && REQ_READY;
   // a response transfers on an edge where RSP_VALID && RSP_READY. RSP_VALID and
   // RSP_DATA_* hold steady until that edge.

   seq_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
   logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rsp_a_q, rsp_a_d;
   logic [DATA_WIDTH-1:0] rsp_b_q, rsp_b_d;
   logic                  wr_done_q, wr_done_d;

   logic                  a_is_r0;
   logic                  b_is_r0;

   assign a_is_r0 = PROTECT_R0 && (addr_a_q == '0);
   assign b_is_r0 = PROTECT_R0 && (addr_b_q == '0);

   always_comb begin
      state_d   = state_q;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      wdata_d   = wdata_q;
      rsp_a_d   = rsp_a_q;
      rsp_b_d   = rsp_b_q;
      wr_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (REQ_VALID) begin
               addr_a_d = REQ_ADDR_A;
               addr_b_d = REQ_ADDR_B;
               wdata_d  = REQ_WDATA;
               state_d  = REQ_WR ? ST_WR_ISSUE : ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE:   state_d = ST_RD_CAPTURE;
         ST_RD_CAPTURE: begin
            // RF drives read data during this cycle; r0 lanes are forced to zero.
            rsp_a_d = a_is_r0 ? '0 : RF_DATA_R1;
            rsp_b_d = b_is_r0 ? '0 : RF_DATA_R2;
            state_d = ST_RSP;
         end
         ST_RSP: begin
            if (RSP_READY) state_d = ST_IDLE;
         end
         ST_WR_ISSUE: begin
            wr_done_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         wdata_q   <= '0;
         rsp_a_q   <= '0;
         rsp_b_q   <= '0;
         wr_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_a_q  <= addr_a_d;
         addr_b_q  <= addr_b_d;
         wdata_q   <= wdata_d;
         rsp_a_q   <= rsp_a_d;
         rsp_b_q   <= rsp_b_d;
         wr_done_q <= wr_done_d;
      end
   end

   // RF control pins decode straight from state, so READ and WRITE are mutually exclusive.
   assign REQ_READY  = (state_q == ST_IDLE);
   assign RF_READ    = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_CAPTURE);
   assign RF_WRITE   = (state_q == ST_WR_ISSUE) && !a_is_r0;
   assign RF_ADDR_R1 = addr_a_q;
   assign RF_ADDR_R2 = addr_b_q;
   assign RF_ADDR_W  = addr_a_q;
   assign RF_DATA_W  = wdata_q;
   assign RSP_VALID  = (state_q == ST_RSP);
   assign RSP_DATA_A = rsp_a_q;
   assign RSP_DATA_B = rsp_b_q;
   assign WR_DONE    = wr_done_q;
   assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Bench: sequencer driving a behavioural 32x32 dual-read register file, checked against
// hand-computed vectors, multi-cycle corner sequences and a reference memory.
module tb_rf_access_sequencer;

   logic        CLK;
   logic        RST;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WR;
   logic [4:0]  REQ_ADDR_A;
   logic [4:0]  REQ_ADDR_B;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [31:0] RSP_DATA_A;
   logic [31:0] RSP_DATA_B;
   logic        WR_DONE;
   logic        RF_READ;
   logic        RF_WRITE;
   logic [4:0]  RF_ADDR_R1;
   logic [4:0]  RF_ADDR_R2;
   logic [4:0]  RF_ADDR_W;
   logic [31:0] RF_DATA_W;
   wire  [31:0] RF_DATA_R1;
   wire  [31:0] RF_DATA_R2;
   logic [2:0]  DBG_STATE;

   int total;
   int bad;

   rf_access_sequencer dut (
      .CLK        (CLK),
      .RST        (RST),
      .REQ_VALID  (REQ_VALID),
      .REQ_READY  (REQ_READY),
      .REQ_WR     (REQ_WR),
      .REQ_ADDR_A (REQ_ADDR_A),
      .REQ_ADDR_B (REQ_ADDR_B),
      .REQ_WDATA  (REQ_WDATA),
      .RSP_VALID  (RSP_VALID),
      .RSP_READY  (RSP_READY),
      .RSP_DATA_A (RSP_DATA_A),
      .RSP_DATA_B (RSP_DATA_B),
      .WR_DONE    (WR_DONE),
      .RF_READ    (RF_READ),
      .RF_WRITE   (RF_WRITE),
      .RF_ADDR_R1 (RF_ADDR_R1),
      .RF_ADDR_R2 (RF_ADDR_R2),
      .RF_ADDR_W  (RF_ADDR_W),
      .RF_DATA_W  (RF_DATA_W),
      .RF_DATA_R1 (RF_DATA_R1),
      .RF_DATA_R2 (RF_DATA_R2),
      .DBG_STATE  (DBG_STATE)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- register file model ----------------
   // Latches read addresses on an edge with READ=1, drives data while READ=1.
   // r0 holds a non-zero pattern so the sequencer's r0 forcing is observable.
   logic [31:0] rf_mem [32];
   logic [31:0] rf_rd1_q;
   logic [31:0] rf_rd2_q;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
         rf_mem[0] <= 32'hBAD0_0BAD;
         rf_rd1_q  <= 32'h0;
         rf_rd2_q  <= 32'h0;
      end else begin
         if (RF_WRITE) rf_mem[RF_ADDR_W] <= RF_DATA_W;
         if (RF_READ && !RF_WRITE) begin
            rf_rd1_q <= rf_mem[RF_ADDR_R1];
            rf_rd2_q <= rf_mem[RF_ADDR_R2];
         end
      end
   end

   assign RF_DATA_R1 = (RF_READ && !RF_WRITE) ? rf_rd1_q : 32'hzzzz_zzzz;
   assign RF_DATA_R2 = (RF_READ && !RF_WRITE) ? rf_rd2_q : 32'hzzzz_zzzz;

   // ---------------- scoreboard ----------------
   logic [31:0] ref_mem [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RST === 1'b1) check("rd_wr_excl", {31'b0, RF_READ & RF_WRITE}, 32'h0);
   end

   // ---------------- driver ----------------
   task automatic do_req(input logic wr, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] d, input int stall,
                         output logic [31:0] ra, output logic [31:0] rb);
      int n;
      ra = 32'h0;
      rb = 32'h0;
      @(negedge CLK);
      REQ_VALID  = 1'b1;
      REQ_WR     = wr;
      REQ_ADDR_A = a;
      REQ_ADDR_B = b;
      REQ_WDATA  = d;
      n = 0;
      while (!REQ_READY && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("accept_timeout", {31'b0, n >= 20}, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      REQ_VALID  = 1'b0;
      REQ_WR     = $urandom_range(0, 1);
      REQ_ADDR_A = 5'($urandom);
      REQ_ADDR_B = 5'($urandom);
      REQ_WDATA  = $urandom;
      if (wr) begin
         check("wr_state", {29'b0, DBG_STATE}, 32'd4);
         check("wr_rf_write", {31'b0, RF_WRITE}, {31'b0, a != 5'd0});
         check("wr_rf_addr", {27'b0, RF_ADDR_W}, {27'b0, a});
         check("wr_rf_data", RF_DATA_W, d);
         check("wr_req_ready", {31'b0, REQ_READY}, 32'h0);
         @(negedge CLK);
         check("wr_done", {31'b0, WR_DONE}, 32'h1);
         check("wr_rf_write_off", {31'b0, RF_WRITE}, 32'h0);
         check("wr_back_idle", {31'b0, REQ_READY}, 32'h1);
      end else begin
         check("rd_issue_state", {29'b0, DBG_STATE}, 32'd1);
         check("rd_issue_read", {31'b0, RF_READ}, 32'h1);
         check("rd_issue_addr", {22'b0, RF_ADDR_R1, RF_ADDR_R2}, {22'b0, a, b});
         check("rd_issue_rsp", {31'b0, RSP_VALID}, 32'h0);
         @(negedge CLK);
         check("rd_cap_state", {29'b0, DBG_STATE}, 32'd2);
         check("rd_cap_read", {31'b0, RF_READ}, 32'h1);
         check("rd_cap_rsp", {31'b0, RSP_VALID}, 32'h0);
         @(negedge CLK);
         check("rsp_valid", {31'b0, RSP_VALID}, 32'h1);
         check("rsp_rf_idle", {30'b0, RF_READ, RF_WRITE}, 32'h0);
         ra = RSP_DATA_A;
         rb = RSP_DATA_B;
         for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            check("bp_valid", {31'b0, RSP_VALID}, 32'h1);
            check("bp_data_a", RSP_DATA_A, ra);
            check("bp_data_b", RSP_DATA_B, rb);
            check("bp_req_ready", {31'b0, REQ_READY}, 32'h0);
            check("bp_rf_idle", {30'b0, RF_READ, RF_WRITE}, 32'h0);
         end
         RSP_READY = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
         RSP_READY = 1'b0;
         check("rsp_drop", {31'b0, RSP_VALID}, 32'h0);
         check("rd_back_idle", {31'b0, REQ_READY}, 32'h1);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic        wr;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [31:0] wdata;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        wr;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [31:0] d;

      vecs[0] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
      vecs[1] = '{1'b0, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b1, 5'd0,  5'd0,  32'h00001234, 32'h0,        32'h0};
      vecs[3] = '{1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
      vecs[4] = '{1'b1, 5'd31, 5'd0,  32'hFFFF0000, 32'h0,        32'h0};
      vecs[5] = '{1'b1, 5'd1,  5'd0,  32'h00000001, 32'h0,        32'h0};
      vecs[6] = '{1'b0, 5'd31, 5'd1,  32'h0,        32'hFFFF0000, 32'h00000001};
      vecs[7] = '{1'b0, 5'd1,  5'd5,  32'h0,        32'h00000001, 32'hDEADBEEF};
      vecs[8] = '{1'b1, 5'd5,  5'd0,  32'hCAFEF00D, 32'h0,        32'h0};
      vecs[9] = '{1'b0, 5'd5,  5'd31, 32'h0,        32'hCAFEF00D, 32'hFFFF0000};

      total = 0;
      bad   = 0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      RST        = 1'b0;
      REQ_VALID  = 1'b0;
      REQ_WR     = 1'b0;
      REQ_ADDR_A = 5'd0;
      REQ_ADDR_B = 5'd0;
      REQ_WDATA  = 32'h0;
      RSP_READY  = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // reset state
      check("rst_req_ready", {31'b0, REQ_READY}, 32'h1);
      check("rst_ctrl", {29'b0, RF_READ, RF_WRITE, WR_DONE}, 32'h0);
      check("rst_rsp_valid", {31'b0, RSP_VALID}, 32'h0);
      check("rst_rsp_data", RSP_DATA_A | RSP_DATA_B, 32'h0);
      check("rst_rf_addr", {17'b0, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W}, 32'h0);
      check("rst_rf_data", RF_DATA_W, 32'h0);

      // reset while in RD_CAPTURE aborts the read with no response
      REQ_VALID  = 1'b1;
      REQ_WR     = 1'b0;
      REQ_ADDR_A = 5'd7;
      REQ_ADDR_B = 5'd9;
      @(negedge CLK);
      REQ_VALID = 1'b0;
      @(negedge CLK);
      check("abort_in_capture", {29'b0, DBG_STATE}, 32'd2);
      RST = 1'b0;
      #1;
      check("abort_rf_read", {31'b0, RF_READ}, 32'h0);
      check("abort_rsp_valid", {31'b0, RSP_VALID}, 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("abort_req_ready", {31'b0, REQ_READY}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("abort_no_rsp", {31'b0, RSP_VALID}, 32'h0);
      end

      // directed vectors
      for (int i = 0; i < 10; i++) begin
         do_req(vecs[i].wr, vecs[i].a, vecs[i].b, vecs[i].wdata, 0, ra, rb);
         if (vecs[i].wr) begin
            if (vecs[i].a != 5'd0) ref_mem[vecs[i].a] = vecs[i].wdata;
         end else begin
            check($sformatf("vec%0d_a", i), ra, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), rb, vecs[i].exp_b);
         end
      end

      // backpressure: response held for 10 stalled cycles
      do_req(1'b0, 5'd31, 5'd5, 32'h0, 10, ra, rb);
      check("bp_final_a", ra, 32'hFFFF0000);
      check("bp_final_b", rb, 32'hCAFEF00D);

      // random mixed traffic against the reference memory
      for (int i = 0; i < 1000; i++) begin
         wr = $urandom_range(0, 1);
         a  = 5'($urandom_range(0, 31));
         b  = 5'($urandom_range(0, 31));
         d  = $urandom;
         do_req(wr, a, b, d, $urandom_range(0, 2), ra, rb);
         if (wr) begin
            if (a != 5'd0) ref_mem[a] = d;
         end else begin
            check("rand_a", ra, (a == 5'd0) ? 32'h0 : ref_mem[a]);
            check("rand_b", rb, (b == 5'd0) ? 32'h0 : ref_mem[b]);
         end
      end

      repeat (2) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
